// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined signed carry-lookahead adder/subtractor.
//
// Stage 1 captures per-bit propagate and, for every BLOCK-bit group, the
// in-group carries for both possible group carry-ins. It also captures the
// group propagate/generate, the carry-in, both operand sign bits and the
// saturate request.
// Stage 2 resolves the group carry-ins with a second-level lookahead. It picks
// the matching in-group carries, forms the raw sum and the flags, and applies
// saturation. The result sits in the output registers.
//
// Handshake (valid/ready): a transfer happens on any rising edge where
// valid and ready are both high. The producer holds its payload while valid
// is high and ready is low. in_ready never depends on in_valid.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b                signed operands (WIDTH bits)
//   sub                 0: a+b, 1: a-b
//   sat                 clamp result to max/min on signed overflow
//   out_valid/out_ready result handshake
//   sum                 result (clamped when sat and overflow)
//   cout                raw carry out of the MSB
//   ovf, uvf            signed positive / negative overflow (pre-saturation)
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             uvf
);

    localparam int NB = WIDTH / BLOCK;

    generate
        if (WIDTH < 4 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
            $error("cla_addsub_pipe: WIDTH must be >= 4 and a multiple of BLOCK");
        end
    endgenerate

    // ---------------- stage 1 combinational ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] lc0;     // carry into each bit, group carry-in = 0
    logic [WIDTH-1:0] lc1;     // carry into each bit, group carry-in = 1
    logic [NB-1:0]    grp_p;
    logic [NB-1:0]    grp_g;
    logic             c0v;
    logic             c1v;
    logic             pk;

    always_comb begin
        b_eff = sub ? ~b : b;
        p     = a ^ b_eff;
        g     = a & b_eff;
        lc0   = '0;
        lc1   = '0;
        grp_p = '0;
        grp_g = '0;
        c0v   = 1'b0;
        c1v   = 1'b1;
        pk    = 1'b1;
        for (int k = 0; k < NB; k++) begin
            c0v = 1'b0;
            c1v = 1'b1;
            pk  = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                lc0[k*BLOCK+j] = c0v;
                lc1[k*BLOCK+j] = c1v;
                c0v = g[k*BLOCK+j] | (p[k*BLOCK+j] & c0v);
                c1v = g[k*BLOCK+j] | (p[k*BLOCK+j] & c1v);
                pk  = pk & p[k*BLOCK+j];
            end
            // Group generate is the group carry-out when its carry-in is 0.
            grp_g[k] = c0v;
            grp_p[k] = pk;
        end
    end

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s2_load;
    logic s1_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ---------------- stage 1 registers ----------------
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_lc0;
    logic [WIDTH-1:0] s1_lc1;
    logic [NB-1:0]    s1_gp;
    logic [NB-1:0]    s1_gg;
    logic             s1_c0;
    logic             s1_sa;
    logic             s1_sb;
    logic             s1_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_lc0   <= '0;
            s1_lc1   <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p   <= p;
                s1_lc0 <= lc0;
                s1_lc1 <= lc1;
                s1_gp  <= grp_p;
                s1_gg  <= grp_g;
                s1_c0  <= sub;
                s1_sa  <= a[WIDTH-1];
                s1_sb  <= b_eff[WIDTH-1];
                s1_sat <= sat;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic [NB:0]      blk_c;
    logic [WIDTH-1:0] raw;
    logic             ovf_n;
    logic             uvf_n;
    logic [WIDTH-1:0] sum_n;

    always_comb begin
        blk_c    = '0;
        raw      = '0;
        blk_c[0] = s1_c0;
        for (int k = 0; k < NB; k++) begin
            blk_c[k+1] = s1_gg[k] | (s1_gp[k] & blk_c[k]);
            for (int j = 0; j < BLOCK; j++) begin
                raw[k*BLOCK+j] = s1_p[k*BLOCK+j] ^
                    (blk_c[k] ? s1_lc1[k*BLOCK+j] : s1_lc0[k*BLOCK+j]);
            end
        end
        ovf_n = ~s1_sa & ~s1_sb &  raw[WIDTH-1];
        uvf_n =  s1_sa &  s1_sb & ~raw[WIDTH-1];
        if (s1_sat && ovf_n)
            sum_n = {1'b0, {(WIDTH-1){1'b1}}};
        else if (s1_sat && uvf_n)
            sum_n = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sum_n = raw;
    end

    // ---------------- stage 2 / output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            uvf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_n;
                cout <= blk_c[NB];
                ovf  <= ovf_n;
                uvf  <= uvf_n;
            end
        end
    end

endmodule
